// File: rtl/pwm_hbridge_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pwm_hbridge_multi
// Purpose  : Multi-channel button-driven signed speed control with shared PWM
//            timebase, period-aligned duty updates and H-bridge dead time.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_hbridge_multi #(
    parameter int CHANNELS        = 2,
    parameter int RESOLUTION_BITS = 8,
    parameter int FRECUENCY_BITS  = 1,
    parameter int STEP            = 16,
    parameter int DEAD_PERIODS    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS-1:0]                 sum,
    input  logic [CHANNELS-1:0]                 rest,
    output logic [CHANNELS-1:0]                 pwm,
    output logic [CHANNELS-1:0]                 in1,
    output logic [CHANNELS-1:0]                 in2,
    output logic [CHANNELS*RESOLUTION_BITS-1:0] speed,
    output logic                                rdy
);

    localparam int c_r  = RESOLUTION_BITS;
    localparam int c_dw = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic signed [c_r:0]  c_step      = (c_r+1)'(STEP);
    localparam logic signed [c_r:0]  c_max       = (c_r+1)'((2**(c_r-1))-1);
    localparam logic [c_dw-1:0]      c_dead_load = c_dw'((DEAD_PERIODS > 0) ? DEAD_PERIODS-1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    function automatic state_t idle_next(input logic signed [c_r-1:0] req);
        if (req > 0)
            return ST_FWD;
        else if (req < 0)
            return ST_REV;
        else
            return ST_IDLE;
    endfunction

    // Shared timebase
    logic [FRECUENCY_BITS-1:0] r_presc;
    logic [c_r-1:0]            r_cnt;
    logic                      r_rdy;
    logic                      w_tick;
    logic                      w_pstart;

    assign w_tick   = &r_presc;
    assign w_pstart = w_tick && (&r_cnt);
    assign rdy      = r_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_presc <= r_presc + FRECUENCY_BITS'(1);
            if (w_tick)
                r_cnt <= r_cnt + c_r'(1);
            r_rdy <= w_pstart;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // bit 0 = sum, bit 1 = rest
        logic [1:0]              r_s1, r_s2, r_s3;
        logic [1:0]              w_press;
        logic signed [c_r-1:0]   r_speed, w_speed_n;
        logic signed [c_r:0]     w_ext, w_up, w_dn;
        state_t                  r_state, w_state_n;
        logic [c_dw-1:0]         r_dcnt, w_dcnt_n;
        logic [c_r-1:0]          r_duty, w_abs, w_duty;
        logic                    r_pwm;

        assign w_press = r_s3 & ~r_s2;
        assign w_ext   = {r_speed[c_r-1], r_speed};
        assign w_up    = w_ext + c_step;
        assign w_dn    = w_ext - c_step;
        assign w_abs   = r_speed[c_r-1] ? c_r'(-r_speed) : c_r'(r_speed);
        assign w_duty  = {w_abs[c_r-2:0], 1'b0};

        // A step that crosses zero lands on zero; magnitude saturates at MAX
        always_comb begin
            w_speed_n = r_speed;
            if (w_press[0] && !w_press[1]) begin
                if (r_speed < 0 && w_up > 0)
                    w_speed_n = '0;
                else if (w_up > c_max)
                    w_speed_n = c_max[c_r-1:0];
                else
                    w_speed_n = w_up[c_r-1:0];
            end else if (w_press[1] && !w_press[0]) begin
                if (r_speed > 0 && w_dn < 0)
                    w_speed_n = '0;
                else if (w_dn < -c_max)
                    w_speed_n = c_r'(-c_max);
                else
                    w_speed_n = w_dn[c_r-1:0];
            end
        end

        always_comb begin
            w_state_n = r_state;
            w_dcnt_n  = r_dcnt;
            if (w_pstart) begin
                case (r_state)
                    ST_IDLE: w_state_n = idle_next(r_speed);
                    ST_FWD, ST_REV: begin
                        if ((r_state == ST_FWD && r_speed > 0) ||
                            (r_state == ST_REV && r_speed < 0)) begin
                            w_state_n = r_state;
                        end else if (DEAD_PERIODS == 0) begin
                            w_state_n = idle_next(r_speed);
                        end else begin
                            w_state_n = ST_DEAD;
                            w_dcnt_n  = c_dead_load;
                        end
                    end
                    ST_DEAD: begin
                        if (r_dcnt == '0)
                            w_state_n = idle_next(r_speed);
                        else
                            w_dcnt_n = r_dcnt - c_dw'(1);
                    end
                    default: w_state_n = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1    <= 2'b11;
                r_s2    <= 2'b11;
                r_s3    <= 2'b11;
                r_speed <= '0;
                r_state <= ST_IDLE;
                r_dcnt  <= '0;
                r_duty  <= '0;
                r_pwm   <= 1'b0;
            end else begin
                r_s1    <= {rest[i], sum[i]};
                r_s2    <= r_s1;
                r_s3    <= r_s2;
                r_speed <= w_speed_n;
                r_state <= w_state_n;
                r_dcnt  <= w_dcnt_n;
                if (w_pstart)
                    r_duty <= w_duty;
                r_pwm <= ((r_state == ST_FWD) || (r_state == ST_REV)) && (r_cnt < r_duty);
            end
        end

        assign pwm[i]              = r_pwm;
        assign in1[i]              = (r_state == ST_FWD);
        assign in2[i]              = (r_state == ST_REV);
        assign speed[i*c_r +: c_r] = r_speed;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_hbridge_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_hbridge_multi
// Purpose  : Directed self-checking bench for pwm_hbridge_multi (2 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_hbridge_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sum, rest, pwm, in1, in2;
    logic [15:0] speed;
    logic        rdy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pwm_hbridge_multi #(
        .CHANNELS(2), .RESOLUTION_BITS(8), .FRECUENCY_BITS(1),
        .STEP(16), .DEAD_PERIODS(2)
    ) dut (
        .clk(clk), .rst(rst), .sum(sum), .rest(rest),
        .pwm(pwm), .in1(in1), .in2(in2), .speed(speed), .rdy(rdy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic press(input int ch, input bit up, input bit dn);
        @(negedge clk);
        if (up) sum[ch]  = 1'b0;
        if (dn) rest[ch] = 1'b0;
        repeat (40) @(negedge clk);
        sum[ch]  = 1'b1;
        rest[ch] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_rdy(output int n);
        bit found = 1'b0;
        n = 0;
        for (int k = 1; k <= 1100 && !found; k++) begin
            @(posedge clk); #1;
            if (rdy) begin
                found = 1'b1;
                n     = k;
            end
        end
        if (!found) check("rdy_timeout", 32'd0, 32'd1);
    endtask

    // Called in the rdy cycle; observes exactly one period and ends in the next rdy cycle
    task automatic measure(input int press_at, output int hi0, output int hi1,
                           output int rdys, output logic [1:0] i1, output logic [1:0] i2);
        hi0 = 0; hi1 = 0; rdys = 0; i1 = 2'b00; i2 = 2'b00;
        for (int k = 0; k < 512; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                i1 = in1;
                i2 = in2;
            end
            hi0  += int'(pwm[0]);
            hi1  += int'(pwm[1]);
            rdys += int'(rdy);
            if (k == press_at)      sum[0] = 1'b0;
            if (k == press_at + 40) sum[0] = 1'b1;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h0, h1, r;
        logic [1:0] d1, d2;

        sum  = 2'b11;
        rest = 2'b11;
        rst  = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("rst_pwm", pwm, 0);
        check("rst_dir", {in1, in2}, 0);
        check("rst_speed", speed, 0);
        check("rst_rdy", rdy, 0);

        @(negedge clk);
        rst = 1'b0;
        wait_rdy(n);
        check("first_rdy_latency", n, 512);
        for (int p = 0; p < 2; p++) begin
            measure(9999, h0, h1, r, d1, d2);
            check("idle_pwm", h0 + h1, 0);
            check("idle_dir", {d1, d2}, 0);
            check("idle_rdy_count", r, 1);
        end
        check("idle_speed", speed, 0);

        // Single press: speed changes exactly at the 3rd rising edge
        @(negedge clk);
        sum[0] = 1'b0;
        @(posedge clk); #1; check("spd_edge1", speed[7:0], 8'd0);
        @(posedge clk); #1; check("spd_edge2", speed[7:0], 8'd0);
        @(posedge clk); #1; check("spd_edge3", speed[7:0], 8'd16);
        repeat (40) @(negedge clk);
        sum[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("no_autorepeat", speed[7:0], 8'd16);
        check("dir_unchanged_mid", in1, 0);

        wait_rdy(n);
        measure(9999, h0, h1, r, d1, d2);
        check("fwd16_pwm0", h0, 64);
        check("fwd16_pwm1", h1, 0);
        check("fwd16_in1", d1, 2'b01);
        check("fwd16_in2", d2, 2'b00);
        check("ch1_speed", speed[15:8], 8'd0);

        // Press 100 clocks into a period: current period keeps its duty
        measure(100, h0, h1, r, d1, d2);
        check("midpress_pwm0", h0, 64);
        check("midpress_speed", speed[7:0], 8'd32);
        measure(9999, h0, h1, r, d1, d2);
        check("next_period_pwm0", h0, 128);

        repeat (7) press(0, 1'b1, 1'b0);
        check("pos_saturate", speed[7:0], 8'd127);
        wait_rdy(n);
        measure(9999, h0, h1, r, d1, d2);
        check("sat_pwm0", h0, 508);

        // Asynchronous reset mid-period, with a press confined to reset
        repeat (100) @(negedge clk);
        check("pre_rst_in1", in1, 2'b01);
        check("pre_rst_pwm", pwm, 2'b01);
        rst = 1'b1;
        #1;
        check("async_rst_pwm", pwm, 0);
        check("async_rst_dir", {in1, in2}, 0);
        check("async_rst_speed", speed, 0);
        @(negedge clk);
        sum[0] = 1'b0;
        repeat (5) @(negedge clk);
        sum[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_spurious_press", speed, 0);

        // FWD -> DEAD (2 periods) -> REV
        press(0, 1'b1, 1'b0);
        check("seq_speed16", speed[7:0], 8'd16);
        wait_rdy(n);
        measure(9999, h0, h1, r, d1, d2);
        check("seq_fwd_pwm0", h0, 64);
        check("seq_fwd_in1", d1, 2'b01);
        press(0, 1'b0, 1'b1);
        check("seq_speed0", speed[7:0], 8'd0);
        press(0, 1'b0, 1'b1);
        check("seq_speed_m16", speed[7:0], 8'hF0);
        wait_rdy(n);
        for (int p = 0; p < 2; p++) begin
            measure(9999, h0, h1, r, d1, d2);
            check("dead_dir", {d1, d2}, 0);
            check("dead_pwm0", h0, 0);
        end
        measure(9999, h0, h1, r, d1, d2);
        check("rev_in1", d1, 2'b00);
        check("rev_in2", d2, 2'b01);
        check("rev_pwm0", h0, 64);

        press(0, 1'b1, 1'b1);
        check("both_no_change", speed[7:0], 8'hF0);
        repeat (7) press(0, 1'b0, 1'b1);
        check("neg_saturate", speed[7:0], 8'h81);
        repeat (7) press(0, 1'b1, 1'b0);
        check("neg_m15", speed[7:0], 8'hF1);
        press(0, 1'b1, 1'b0);
        check("zero_clamp", speed[7:0], 8'd0);
        check("ch1_final", {speed[15:8], in1[1], in2[1]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
